// File: rtl/riscv_defs.sv
// Shared RV32 decode definitions: base opcodes, datapath width and the
// decoded class-flag bundle handed from decode to execute.
package riscv_defs;

  localparam int XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  typedef struct packed {
    logic is_store;
    logic is_load;
    logic is_branch;
    logic is_jump;
    logic is_reg;
    logic is_alu;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one write port,
// x0 reads as zero and ignores writes; asynchronous reset clears every entry.
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wen && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage: decodes fetch's instruction, reads operands, tracks pending
// destinations in a scoreboard and registers one bundle for execute.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data into the operands.
module decode_stage #(
  parameter int XLEN  = riscv_defs::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_dest,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            is_store,
  output logic            is_load,
  output logic            is_branch,
  output logic            is_jump,
  output logic            is_reg,
  output logic            is_alu,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] branch_dest,
  output logic [4:0]      dest,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [XLEN-1:0] curr_pc,
  output logic            illegal
);
  import riscv_defs::*;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  logic [XLEN-1:0] rf_a, rf_b, src_a, src_b;
  logic            fwd_a, fwd_b;

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .wen     (wb_en),
    .waddr   (wb_dest),
    .wdata   (wb_data)
  );

`ifdef DECODE_BYPASS_EN
  assign fwd_a = wb_en && (wb_dest == rs1) && (rs1 != 5'd0);
  assign fwd_b = wb_en && (wb_dest == rs2) && (rs2 != 5'd0);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif
  assign src_a = fwd_a ? wb_data : rf_a;
  assign src_b = fwd_b ? wb_data : rf_b;

  flags_t          d_flags;
  logic [XLEN-1:0] d_a, d_b, d_bd;
  logic [4:0]      d_dest;
  logic [2:0]      d_f3;
  logic            d_f7, use_rs1, use_rs2, writes_rd;

  always_comb begin
    d_flags   = '0;
    d_a       = '0;
    d_b       = '0;
    d_bd      = '0;
    d_dest    = '0;
    d_f3      = '0;
    d_f7      = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OP:     begin d_flags.is_alu = 1'b1; d_flags.is_reg = 1'b1; d_a = src_a; d_b = src_b;
                    d_dest = rd; d_f3 = f3; d_f7 = instr[30]; use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1; end
      OP_IMM: begin d_flags.is_alu = 1'b1; d_a = src_a; d_b = imm_i; d_dest = rd; d_f3 = f3;
                    d_f7 = (f3 == 3'b101) ? instr[30] : 1'b0; use_rs1 = 1'b1; writes_rd = 1'b1; end
      LUI:    begin d_flags.is_alu = 1'b1; d_b = imm_u; d_dest = rd; writes_rd = 1'b1; end
      AUIPC:  begin d_flags.is_alu = 1'b1; d_a = instr_pc; d_b = imm_u; d_dest = rd; writes_rd = 1'b1; end
      BRANCH: begin d_flags.is_branch = 1'b1; d_a = src_a; d_b = src_b; d_bd = imm_b; d_f3 = f3;
                    use_rs1 = 1'b1; use_rs2 = 1'b1; end
      JAL:    begin d_flags.is_jump = 1'b1; d_a = imm_j; d_dest = rd; writes_rd = 1'b1; end
      JALR:   begin d_flags.is_jump = 1'b1; d_flags.is_reg = 1'b1; d_a = src_a; d_b = imm_i;
                    d_dest = rd; d_f3 = f3; use_rs1 = 1'b1; writes_rd = 1'b1; end
      LOAD:   begin d_flags.is_load = 1'b1; d_a = src_a; d_b = imm_i; d_dest = rd; d_f3 = f3;
                    use_rs1 = 1'b1; writes_rd = 1'b1; end
      STORE:  begin d_flags.is_store = 1'b1; d_a = src_a; d_b = imm_s; d_bd = src_b; d_f3 = f3;
                    use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default: d_flags.illegal = 1'b1;
    endcase
  end

  // A source being written back this cycle is only safe to read when it is forwarded.
  logic [NREGS-1:0] pending, pending_next;
  logic             hazard, accept, vld_p1;

  assign hazard = (use_rs1 && pending[rs1] && !fwd_a) ||
                  (use_rs2 && pending[rs2] && !fwd_b) ||
                  (writes_rd && rd != 5'd0 && pending[rd]);
  assign instr_ready = (!vld_p1 || out_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    pending_next = pending;
    if (wb_en) pending_next[wb_dest] = 1'b0;
    if (accept && writes_rd && rd != 5'd0) pending_next[rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

  // ---- stage p1: bundle presented to execute ----
  flags_t          flags_p1;
  logic [XLEN-1:0] opa_p1, opb_p1, bdest_p1, pc_p1;
  logic [4:0]      dest_p1;
  logic [2:0]      f3_p1;
  logic            f7_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      flags_p1 <= '0;
      opa_p1   <= '0;
      opb_p1   <= '0;
      bdest_p1 <= '0;
      dest_p1  <= '0;
      f3_p1    <= '0;
      f7_p1    <= 1'b0;
      pc_p1    <= '0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      flags_p1 <= d_flags;
      opa_p1   <= d_a;
      opb_p1   <= d_b;
      bdest_p1 <= d_bd;
      dest_p1  <= d_dest;
      f3_p1    <= d_f3;
      f7_p1    <= d_f7;
      pc_p1    <= instr_pc;
    end else if (out_ready) begin
      vld_p1   <= 1'b0;
      flags_p1 <= '0;
      dest_p1  <= '0;
    end
  end

  assign out_valid   = vld_p1;
  assign is_store    = flags_p1.is_store;
  assign is_load     = flags_p1.is_load;
  assign is_branch   = flags_p1.is_branch;
  assign is_jump     = flags_p1.is_jump;
  assign is_reg      = flags_p1.is_reg;
  assign is_alu      = flags_p1.is_alu;
  assign illegal     = flags_p1.illegal;
  assign operand_a   = opa_p1;
  assign operand_b   = opb_p1;
  assign branch_dest = bdest_p1;
  assign dest        = dest_p1;
  assign func3       = f3_p1;
  assign func7       = f7_p1;
  assign curr_pc     = pc_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow the
// build's DECODE_BYPASS_EN setting.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic        is_store, is_load, is_branch, is_jump, is_reg, is_alu;
  logic [31:0] operand_a, operand_b, branch_dest, curr_pc;
  logic [4:0]  dest;
  logic [2:0]  func3;
  logic        func7, illegal;

  int total = 0;
  int bad   = 0;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .is_store(is_store), .is_load(is_load), .is_branch(is_branch), .is_jump(is_jump),
    .is_reg(is_reg), .is_alu(is_alu),
    .operand_a(operand_a), .operand_b(operand_b), .branch_dest(branch_dest),
    .dest(dest), .func3(func3), .func7(func7), .curr_pc(curr_pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [5:0] flags;
  assign flags = {is_store, is_load, is_branch, is_jump, is_reg, is_alu};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    wb_en = 1'b1; wb_dest = r; wb_data = v;
    cyc();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] pc);
    instr_valid = 1'b1; instr = i; instr_pc = pc;
    cyc();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
    total++; if ({flags, illegal} !== 7'd0) begin bad++; $display("FAIL rst_flags got=%b exp=0", {flags, illegal}); end
    total++; if ({operand_a, operand_b, branch_dest} !== 96'd0) begin bad++;
      $display("FAIL rst_operands got=%h %h %h exp=0", operand_a, operand_b, branch_dest); end
    total++; if ({dest, func3, func7, curr_pc} !== 41'd0) begin bad++;
      $display("FAIL rst_misc got=%h %h %b %h exp=0", dest, func3, func7, curr_pc); end
    // x5 written after reset, read back through sw x6,8(x5)
    wb(5'd5, 32'h1234);
    issue(32'h0062A423, 32'd4);
    total++; if (operand_a !== 32'h1234) begin bad++; $display("FAIL rst_wb_read got=%h exp=%h", operand_a, 32'h1234); end
    total++; if (branch_dest !== 32'd0) begin bad++; $display("FAIL rst_x6_zero got=%h exp=0", branch_dest); end
  endtask

  task automatic test_branch();
    wb(5'd5, 32'd200);
    wb(5'd6, 32'd200);
    issue(32'h00628A63, 32'd20);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL br_valid got=%b exp=1", out_valid); end
    total++; if (flags !== 6'b001000) begin bad++; $display("FAIL br_flags got=%b exp=001000", flags); end
    total++; if (operand_a !== 32'd200 || operand_b !== 32'd200) begin bad++;
      $display("FAIL br_ops got=%0d,%0d exp=200,200", operand_a, operand_b); end
    total++; if (branch_dest !== 32'd20) begin bad++; $display("FAIL br_dest got=%0d exp=20", branch_dest); end
    total++; if ({func3, dest} !== 8'd0) begin bad++; $display("FAIL br_f3_rd got=%0d,%0d exp=0,0", func3, dest); end
    total++; if (curr_pc !== 32'd20) begin bad++; $display("FAIL br_pc got=%0d exp=20", curr_pc); end
  endtask

  task automatic test_store();
    wb(5'd6, 32'd300);
    issue(32'h0062A423, 32'd24);
    total++; if (flags !== 6'b100000) begin bad++; $display("FAIL st_flags got=%b exp=100000", flags); end
    total++; if (operand_a !== 32'd200 || operand_b !== 32'd8) begin bad++;
      $display("FAIL st_ops got=%0d,%0d exp=200,8", operand_a, operand_b); end
    total++; if (branch_dest !== 32'd300) begin bad++; $display("FAIL st_rs2 got=%0d exp=300", branch_dest); end
    total++; if (dest !== 5'd0 || func3 !== 3'd2) begin bad++;
      $display("FAIL st_rd_f3 got=%0d,%0d exp=0,2", dest, func3); end
  endtask

  task automatic test_alu_imm();
    issue(32'hF9C00493, 32'd28);
    total++; if (flags !== 6'b000001) begin bad++; $display("FAIL addi_flags got=%b exp=000001", flags); end
    total++; if (operand_a !== 32'd0 || operand_b !== 32'hFFFFFF9C) begin bad++;
      $display("FAIL addi_ops got=%h,%h exp=0,ffffff9c", operand_a, operand_b); end
    total++; if (dest !== 5'd9 || func7 !== 1'b0) begin bad++;
      $display("FAIL addi_rd_f7 got=%0d,%b exp=9,0", dest, func7); end
  endtask

  task automatic test_hazard();
    instr_valid = 1'b1; instr = 32'h00948533; instr_pc = 32'd32;
    #1;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL raw_stall0 got=%b exp=0", instr_ready); end
    for (int k = 0; k < 2; k++) begin
      cyc();
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL raw_stall%0d got=%b exp=0", k + 1, instr_ready); end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL raw_bubble got=%b exp=0", out_valid); end
    wb_en = 1'b1; wb_dest = 5'd9; wb_data = 32'd7;
    #1;
`ifdef DECODE_BYPASS_EN
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL raw_wb_ready got=%b exp=1", instr_ready); end
    cyc();
    wb_en = 1'b0; instr_valid = 1'b0;
`else
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL raw_wb_ready got=%b exp=0", instr_ready); end
    cyc();
    wb_en = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || instr_ready !== 1'b1) begin bad++;
      $display("FAIL raw_after_wb got=%b,%b exp=0,1", out_valid, instr_ready); end
    cyc();
    instr_valid = 1'b0;
`endif
    total++; if (out_valid !== 1'b1 || flags !== 6'b000011) begin bad++;
      $display("FAIL raw_issue got=%b,%b exp=1,000011", out_valid, flags); end
    total++; if (operand_a !== 32'd7 || operand_b !== 32'd7) begin bad++;
      $display("FAIL raw_ops got=%0d,%0d exp=7,7", operand_a, operand_b); end
    total++; if (dest !== 5'd10 || curr_pc !== 32'd32) begin bad++;
      $display("FAIL raw_rd_pc got=%0d,%0d exp=10,32", dest, curr_pc); end
    wb(5'd10, 32'd14);
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    issue(32'h00628A63, 32'd100);
    instr_valid = 1'b1; instr = 32'h123451B7; instr_pc = 32'd104;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (instr_ready !== 1'b0 || out_valid !== 1'b1) begin bad++;
        $display("FAIL hold_hs%0d got=%b,%b exp=0,1", k, instr_ready, out_valid); end
      total++; if (flags !== 6'b001000 || curr_pc !== 32'd100) begin bad++;
        $display("FAIL hold_ctl%0d got=%b,%0d exp=001000,100", k, flags, curr_pc); end
      total++; if ({operand_a, operand_b, branch_dest} !== {32'd200, 32'd300, 32'd20}) begin bad++;
        $display("FAIL hold_ops%0d got=%0d,%0d,%0d exp=200,300,20", k, operand_a, operand_b, branch_dest); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL hold_release got=%b exp=1", instr_ready); end
    cyc();
    instr_valid = 1'b0;
    total++; if (flags !== 6'b000001 || dest !== 5'd3 || curr_pc !== 32'd104) begin bad++;
      $display("FAIL lui_ctl got=%b,%0d,%0d exp=000001,3,104", flags, dest, curr_pc); end
    total++; if (operand_a !== 32'd0 || operand_b !== 32'h12345000) begin bad++;
      $display("FAIL lui_ops got=%h,%h exp=0,12345000", operand_a, operand_b); end
  endtask

  task automatic test_illegal();
    issue(32'h0000000F, 32'd200);
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin bad++;
      $display("FAIL ill_pulse got=%b,%b exp=1,1", out_valid, illegal); end
    total++; if (flags !== 6'd0 || dest !== 5'd0 || curr_pc !== 32'd200) begin bad++;
      $display("FAIL ill_bundle got=%b,%0d,%0d exp=0,0,200", flags, dest, curr_pc); end
    cyc();
    total++; if (out_valid !== 1'b0 || illegal !== 1'b0 || flags !== 6'd0 || dest !== 5'd0) begin bad++;
      $display("FAIL bubble got=%b,%b,%b,%0d exp=0,0,0,0", out_valid, illegal, flags, dest); end
  endtask

  task automatic test_reset_mid();
    instr_valid = 1'b1; instr = 32'h0062A423; instr_pc = 32'd300;
    @(posedge clk);
    instr_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || curr_pc !== 32'd0) begin bad++;
      $display("FAIL mid_rst got=%b,%0d exp=0,0", out_valid, curr_pc); end
    cyc();
    reset = 1'b0;
    // x3 was left pending by the earlier lui; reset must have cleared it
    instr_valid = 1'b1; instr = 32'h123451B7; instr_pc = 32'd308;
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL mid_sb_clear got=%b exp=1", instr_ready); end
    cyc();
    instr_valid = 1'b0;
    total++; if (dest !== 5'd3) begin bad++; $display("FAIL mid_lui got=%0d exp=3", dest); end
    issue(32'h0062A423, 32'd312);
    total++; if (operand_a !== 32'd0 || branch_dest !== 32'd0 || operand_b !== 32'd8) begin bad++;
      $display("FAIL mid_rf_clear got=%0d,%0d,%0d exp=0,0,8", operand_a, branch_dest, operand_b); end
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; instr_pc = '0;
    wb_en = 1'b0; wb_dest = '0; wb_data = '0; out_ready = 1'b1;
    test_reset();
    test_branch();
    test_store();
    test_alu_imm();
    test_hazard();
    test_hold();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
